// File: rtl/banana_tracker.sv
// Banana collection tracker.
// Latches per-banana collision strobes into a sticky mask, keeps a registered
// population count of that mask, runs an IDLE/PLAY/DONE level state machine
// and accumulates a saturating BCD running total across levels for the score
// display.
module banana_tracker #(
   parameter int N_BANANAS    = 5,
   parameter int TOTAL_DIGITS = 2,
   parameter int CNT_W        = $clog2(N_BANANAS + 1)
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      level_start,
   input  logic [N_BANANAS-1:0]      collide,
   output logic [N_BANANAS-1:0]      collected,
   output logic [CNT_W-1:0]          count,
   output logic                      pickup,
   output logic                      all_collected,
   output logic                      playing,
   output logic [4*TOTAL_DIGITS-1:0] total_bcd
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;

   logic [N_BANANAS-1:0]      newBits;
   logic [N_BANANAS-1:0]      nextCollected;
   logic [3:0]                newCount;
   logic [3:0]                nextPop;
   logic [4*TOTAL_DIGITS-1:0] bcdSum;
   logic [4:0]                digitSum;
   logic [4:0]                carry;

   // Population count of a banana mask; at most nine bananas, so four bits suffice.
   function automatic logic [3:0] popCount(input logic [N_BANANAS-1:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < N_BANANAS; i++) begin
         c = c + {3'b000, v[i]};
      end
      return c;
   endfunction

   // Bananas newly hit this cycle; only PLAY accepts them, and a level restart drops them.
   always_comb begin
      newBits = '0;
      if (state == PLAY && !level_start) begin
         newBits = collide & ~collected;
      end
      nextCollected = collected | newBits;
      newCount      = popCount(newBits);
      nextPop       = popCount(nextCollected);
   end

   // Ripple the new-banana count through the BCD digits; a carry out of the top digit pins the total at all nines.
   always_comb begin
      bcdSum   = '0;
      digitSum = '0;
      carry    = {1'b0, newCount};
      for (int d = 0; d < TOTAL_DIGITS; d++) begin
         digitSum = {1'b0, total_bcd[4*d +: 4]} + carry;
         if (digitSum > 5'd9) begin
            bcdSum[4*d +: 4] = 4'(digitSum - 5'd10);
            carry            = 5'd1;
         end else begin
            bcdSum[4*d +: 4] = digitSum[3:0];
            carry            = 5'd0;
         end
      end
      if (carry != 5'd0) begin
         bcdSum = {TOTAL_DIGITS{4'h9}};
      end
   end

   // Level state machine with every output held in a register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state         <= IDLE;
         collected     <= '0;
         count         <= '0;
         pickup        <= 1'b0;
         all_collected <= 1'b0;
         playing       <= 1'b0;
         total_bcd     <= '0;
      end else if (level_start) begin
         state         <= PLAY;
         collected     <= '0;
         count         <= '0;
         pickup        <= 1'b0;
         all_collected <= 1'b0;
         playing       <= 1'b1;
      end else begin
         case (state)
            PLAY: begin
               collected <= nextCollected;
               count     <= CNT_W'(nextPop);
               pickup    <= |newBits;
               total_bcd <= bcdSum;
               if (&nextCollected) begin
                  state         <= DONE;
                  all_collected <= 1'b1;
                  playing       <= 1'b0;
               end
            end
            default: begin
               pickup <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_banana_tracker.sv
// Directed testbench for banana_tracker.
// A five-banana instance carries most of the sequence; a nine-banana instance
// shares the clock, reset and level_start and is checked at the full-mask and
// asynchronous-reset steps.
module tb_banana_tracker;

   logic       Clk;
   logic       Reset;
   logic       levelStart;
   logic [8:0] collide9;

   logic [4:0] collected5;
   logic [2:0] count5;
   logic       pickup5;
   logic       allCollected5;
   logic       playing5;
   logic [7:0] total5;

   logic [8:0] collected9;
   logic [3:0] count9;
   logic       pickup9;
   logic       allCollected9;
   logic       playing9;
   logic [7:0] total9;

   int checks;
   int errors;
   int expTotal;

   banana_tracker #(.N_BANANAS(5), .TOTAL_DIGITS(2)) dut5 (
      .Clk           (Clk),
      .Reset         (Reset),
      .level_start   (levelStart),
      .collide       (collide9[4:0]),
      .collected     (collected5),
      .count         (count5),
      .pickup        (pickup5),
      .all_collected (allCollected5),
      .playing       (playing5),
      .total_bcd     (total5)
   );

   banana_tracker #(.N_BANANAS(9), .TOTAL_DIGITS(2)) dut9 (
      .Clk           (Clk),
      .Reset         (Reset),
      .level_start   (levelStart),
      .collide       (collide9),
      .collected     (collected9),
      .count         (count9),
      .pickup        (pickup9),
      .all_collected (allCollected9),
      .playing       (playing9),
      .total_bcd     (total9)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Drive one cycle of inputs, then settle just after the rising edge that samples them.
   task automatic applyStimulus(input logic ls, input logic [8:0] col);
      levelStart = ls;
      collide9   = col;
      @(posedge Clk);
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse Reset between clock edges, starting just after an edge.
   task automatic pulseReset();
      Reset = 1'b1;
      #3;
      Reset = 1'b0;
   endtask

   // Directed sequence.
   initial begin
      checks     = 0;
      errors     = 0;
      levelStart = 1'b0;
      collide9   = '0;
      Reset      = 1'b0;
      #1;
      Reset = 1'b1;
      #2;
      checkOutput("reset_collected", 32'(collected5), 32'h0);
      checkOutput("reset_count", 32'(count5), 32'h0);
      checkOutput("reset_pickup", 32'(pickup5), 32'h0);
      checkOutput("reset_all", 32'(allCollected5), 32'h0);
      checkOutput("reset_playing", 32'(playing5), 32'h0);
      checkOutput("reset_total", 32'(total5), 32'h0);
      @(posedge Clk);
      @(posedge Clk);
      #3;
      Reset = 1'b0;

      $display("[TB] step 1: collide while IDLE");
      applyStimulus(1'b0, 9'b00001);
      checkOutput("idle_collected", 32'(collected5), 32'h0);
      checkOutput("idle_count", 32'(count5), 32'h0);
      checkOutput("idle_pickup", 32'(pickup5), 32'h0);
      checkOutput("idle_total", 32'(total5), 32'h00);

      $display("[TB] step 2: single banana held for four cycles");
      applyStimulus(1'b1, 9'b0);
      checkOutput("start_playing", 32'(playing5), 32'h1);
      applyStimulus(1'b0, 9'b00100);
      checkOutput("hold1_collected", 32'(collected5), 32'h04);
      checkOutput("hold1_count", 32'(count5), 32'h1);
      checkOutput("hold1_pickup", 32'(pickup5), 32'h1);
      checkOutput("hold1_total", 32'(total5), 32'h01);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 9'b00100);
         checkOutput("holdN_pickup", 32'(pickup5), 32'h0);
         checkOutput("holdN_count", 32'(count5), 32'h1);
         checkOutput("holdN_total", 32'(total5), 32'h01);
      end

      $display("[TB] step 3: four bananas at once, then the last one");
      applyStimulus(1'b0, 9'b0);
      pulseReset();
      applyStimulus(1'b1, 9'b0);
      checkOutput("lvl_count0", 32'(count5), 32'h0);
      applyStimulus(1'b0, 9'b11011);
      checkOutput("multi_count", 32'(count5), 32'h4);
      checkOutput("multi_pickup", 32'(pickup5), 32'h1);
      checkOutput("multi_all", 32'(allCollected5), 32'h0);
      checkOutput("multi_total", 32'(total5), 32'h04);
      applyStimulus(1'b0, 9'b00100);
      checkOutput("last_count", 32'(count5), 32'h5);
      checkOutput("last_pickup", 32'(pickup5), 32'h1);
      checkOutput("last_collected", 32'(collected5), 32'h1F);
      checkOutput("last_all", 32'(allCollected5), 32'h1);
      checkOutput("last_playing", 32'(playing5), 32'h0);
      checkOutput("last_total", 32'(total5), 32'h05);

      $display("[TB] step 4: DONE ignores collide, level_start beats collide");
      applyStimulus(1'b0, 9'b11111);
      checkOutput("done_collected", 32'(collected5), 32'h1F);
      checkOutput("done_pickup", 32'(pickup5), 32'h0);
      checkOutput("done_all", 32'(allCollected5), 32'h1);
      checkOutput("done_total", 32'(total5), 32'h05);
      applyStimulus(1'b1, 9'b00001);
      checkOutput("restart_collected", 32'(collected5), 32'h0);
      checkOutput("restart_count", 32'(count5), 32'h0);
      checkOutput("restart_pickup", 32'(pickup5), 32'h0);
      checkOutput("restart_playing", 32'(playing5), 32'h1);
      checkOutput("restart_all", 32'(allCollected5), 32'h0);
      checkOutput("restart_total", 32'(total5), 32'h05);

      $display("[TB] step 5: twenty full levels, total saturates");
      pulseReset();
      for (int lvl = 1; lvl <= 19; lvl++) begin
         applyStimulus(1'b1, 9'b0);
         applyStimulus(1'b0, 9'b11111);
         expTotal = ((5 * lvl / 10) << 4) | ((5 * lvl) % 10);
         checkOutput("level_total", 32'(total5), 32'(expTotal));
      end
      checkOutput("lvl19_total", 32'(total5), 32'h95);
      applyStimulus(1'b1, 9'b0);
      applyStimulus(1'b0, 9'b11111);
      checkOutput("sat_total", 32'(total5), 32'h99);
      checkOutput("sat_pickup", 32'(pickup5), 32'h1);
      applyStimulus(1'b1, 9'b0);
      applyStimulus(1'b0, 9'b00011);
      checkOutput("sat_hold_total", 32'(total5), 32'h99);
      checkOutput("sat_hold_count", 32'(count5), 32'h2);

      $display("[TB] step 6: asynchronous reset mid-cycle");
      pulseReset();
      applyStimulus(1'b1, 9'b0);
      applyStimulus(1'b0, 9'b01010);
      checkOutput("pre_collected", 32'(collected5), 32'h0A);
      checkOutput("pre_count", 32'(count5), 32'h2);
      #2;
      Reset = 1'b1;
      #1;
      checkOutput("arst_collected", 32'(collected5), 32'h0);
      checkOutput("arst_count", 32'(count5), 32'h0);
      checkOutput("arst_pickup", 32'(pickup5), 32'h0);
      checkOutput("arst_playing", 32'(playing5), 32'h0);
      checkOutput("arst_total", 32'(total5), 32'h0);
      #1;
      Reset = 1'b0;
      applyStimulus(1'b0, 9'b00001);
      checkOutput("arst_idle_collected", 32'(collected5), 32'h0);
      checkOutput("arst_idle_playing", 32'(playing5), 32'h0);

      $display("[TB] step 6b: nine-banana instance, full mask then reset");
      pulseReset();
      applyStimulus(1'b1, 9'b0);
      applyStimulus(1'b0, 9'h1FF);
      checkOutput("n9_collected", 32'(collected9), 32'h1FF);
      checkOutput("n9_count", 32'(count9), 32'h9);
      checkOutput("n9_all", 32'(allCollected9), 32'h1);
      checkOutput("n9_pickup", 32'(pickup9), 32'h1);
      checkOutput("n9_total", 32'(total9), 32'h09);
      #2;
      Reset = 1'b1;
      #1;
      checkOutput("n9_arst_collected", 32'(collected9), 32'h0);
      checkOutput("n9_arst_count", 32'(count9), 32'h0);
      checkOutput("n9_arst_all", 32'(allCollected9), 32'h0);
      checkOutput("n9_arst_pickup", 32'(pickup9), 32'h0);
      checkOutput("n9_arst_total", 32'(total9), 32'h0);
      #1;
      Reset = 1'b0;
      applyStimulus(1'b0, 9'h1FF);
      checkOutput("n9_idle_collected", 32'(collected9), 32'h0);
      checkOutput("n9_idle_playing", 32'(playing9), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
